// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - main control FSM for the multicycle MIPS core
//
// Decides, cycle by cycle, the ALU operation class and every datapath enable
// and mux select. Memory states wait on a ready handshake, and a bounded wait
// counter faults a stalled memory into the ILLEGAL state.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode              instr[31:26] from the IR
//   mem_ready           memory completes the current access this cycle
//   alu_op              000 add, 001 subtract, 010 R-type (use func)
//   alu_src_a/b         ALU operand selects
//   pc_source           00 ALU result, 01 ALUOut, 10 jump target
//   pc_write(_cond)     PC enables (the datapath ANDs _cond with zero)
//   i_or_d              memory address select (0 PC, 1 ALUOut)
//   mem_read/mem_write  memory strobes
//   ir_write            instruction register load
//   reg_write/reg_dst/mem_to_reg  register-file writeback controls
//   illegal_op          sticky: unknown opcode decoded
//   mem_timeout         sticky: memory wait exceeded TIMEOUT
//   state               current state, for debug
module multicycle_main_control #(
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic [2:0]      alu_op,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_source,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            illegal_op,
  output logic            mem_timeout,
  output logic [3:0]      state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_ILLEGAL   = 4'd13
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);

  // Counter only needs to reach TIMEOUT; with the timeout disabled it is a
  // single saturating bit that has no effect.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // The fault is taken in the wait cycle that would bring the count to
  // TIMEOUT, so compare against TIMEOUT-1 before the increment.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             illegal_q;
  logic             timeout_q;
  logic             in_mem_state;
  logic             timeout_hit;

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                        (state_q == S_MEM_WRITE);
  // Ready wins: a completing access never faults.
  assign timeout_hit  = (TIMEOUT != 0) && in_mem_state && !mem_ready &&
                        (wait_cnt == TO_LAST);

  // State register, wait counter and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Any state change clears the count, which covers every entry into a
      // memory state.
      if (state_d != state_q) begin
        wait_cnt <= '0;
      end else if (in_mem_state && !mem_ready && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if ((state_q == S_DECODE) && (state_d == S_ILLEGAL)) begin
        illegal_q <= 1'b1;
      end
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_ILLEGAL;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      // Only lw and sw reach MEM_ADDR, so sw is the sole write case.
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_ready)        state_d = S_MEM_WB;
        else if (timeout_hit) state_d = S_ILLEGAL;
      end
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready)        state_d = S_FETCH;
        else if (timeout_hit) state_d = S_ILLEGAL;
      end
      S_EXECUTE:   state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_ILLEGAL:   state_d = S_ILLEGAL;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output logic: Moore except the FETCH enables gated by mem_ready
  always_comb begin
    alu_op        = 3'b000;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - directed self-checking bench for multicycle_main_control
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, illegal_op, mem_timeout;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_main_control #(.OP_W(6), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .state(state)
  );

  // Packed view: {state, alu_op, alu_src_a, alu_src_b, pc_source, enables}
  logic [22:0] act;
  assign act = {state, alu_op, alu_src_a, alu_src_b, pc_source,
                pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, illegal_op, mem_timeout};

  localparam logic [10:0] PW  = 11'h400, PWC = 11'h200, IOD = 11'h100;
  localparam logic [10:0] MR  = 11'h080, MW  = 11'h040, IRW = 11'h020;
  localparam logic [10:0] RW  = 11'h010, RD  = 11'h008, MTR = 11'h004;
  localparam logic [10:0] IOP = 11'h002, MT  = 11'h001;

  localparam logic [22:0] E_IDLE    = 23'd0;
  localparam logic [22:0] E_FETCH_R = {4'd1,  3'b000, 1'b0, 2'b01, 2'b00, PW | IRW | MR};
  localparam logic [22:0] E_FETCH_W = {4'd1,  3'b000, 1'b0, 2'b01, 2'b00, MR};
  localparam logic [22:0] E_DECODE  = {4'd2,  3'b000, 1'b0, 2'b11, 2'b00, 11'h000};
  localparam logic [22:0] E_MADDR   = {4'd3,  3'b000, 1'b1, 2'b10, 2'b00, 11'h000};
  localparam logic [22:0] E_MREAD   = {4'd4,  3'b000, 1'b0, 2'b00, 2'b00, MR | IOD};
  localparam logic [22:0] E_MWB     = {4'd5,  3'b000, 1'b0, 2'b00, 2'b00, RW | MTR};
  localparam logic [22:0] E_MWRITE  = {4'd6,  3'b000, 1'b0, 2'b00, 2'b00, MW | IOD};
  localparam logic [22:0] E_EXEC    = {4'd7,  3'b010, 1'b1, 2'b00, 2'b00, 11'h000};
  localparam logic [22:0] E_RWB     = {4'd8,  3'b000, 1'b0, 2'b00, 2'b00, RW | RD};
  localparam logic [22:0] E_BRANCH  = {4'd9,  3'b001, 1'b1, 2'b00, 2'b01, PWC};
  localparam logic [22:0] E_JUMP    = {4'd10, 3'b000, 1'b0, 2'b00, 2'b10, PW};
  localparam logic [22:0] E_AEXEC   = {4'd11, 3'b000, 1'b1, 2'b10, 2'b00, 11'h000};
  localparam logic [22:0] E_AWB     = {4'd12, 3'b000, 1'b0, 2'b00, 2'b00, RW};
  localparam logic [22:0] E_ILL_OP  = {4'd13, 3'b000, 1'b0, 2'b00, 2'b00, IOP};
  localparam logic [22:0] E_ILL_TO  = {4'd13, 3'b000, 1'b0, 2'b00, 2'b00, MT};

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [22:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic add(input logic [5:0] op, input logic rdy, input logic [22:0] exp);
    vec_t v;
    v.op = op; v.rdy = rdy; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [22:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive inputs at the falling edge, settle, compare, advance one cycle.
  task automatic step(input string name, input logic [5:0] op, input logic rdy,
                      input logic [22:0] exp);
    opcode = op;
    mem_ready = rdy;
    #1;
    check(name, exp);
    @(negedge clk);
  endtask

  initial begin
    // R-type, zero wait states
    add(RT, 1'b0, E_IDLE);
    add(RT, 1'b1, E_FETCH_R);  add(RT, 1'b1, E_DECODE);
    add(RT, 1'b1, E_EXEC);     add(RT, 1'b1, E_RWB);
    // lw with two wait cycles in MEM_READ
    add(LW, 1'b1, E_FETCH_R);  add(LW, 1'b1, E_DECODE);  add(LW, 1'b1, E_MADDR);
    add(LW, 1'b0, E_MREAD);    add(LW, 1'b0, E_MREAD);   add(LW, 1'b1, E_MREAD);
    add(LW, 1'b1, E_MWB);
    // sw with a fetch wait and a write wait
    add(SW, 1'b0, E_FETCH_W);  add(SW, 1'b1, E_FETCH_R); add(SW, 1'b1, E_DECODE);
    add(SW, 1'b1, E_MADDR);    add(SW, 1'b0, E_MWRITE);  add(SW, 1'b1, E_MWRITE);
    // beq, j, addi
    add(BEQ, 1'b1, E_FETCH_R); add(BEQ, 1'b1, E_DECODE); add(BEQ, 1'b1, E_BRANCH);
    add(J, 1'b1, E_FETCH_R);   add(J, 1'b1, E_DECODE);   add(J, 1'b1, E_JUMP);
    add(ADDI, 1'b1, E_FETCH_R); add(ADDI, 1'b1, E_DECODE);
    add(ADDI, 1'b1, E_AEXEC);  add(ADDI, 1'b1, E_AWB);
    // Ready arrives in the cycle the count reaches TIMEOUT: completes normally
    add(RT, 1'b0, E_FETCH_W);  add(RT, 1'b0, E_FETCH_W); add(RT, 1'b0, E_FETCH_W);
    add(RT, 1'b1, E_FETCH_R);  add(RT, 1'b1, E_DECODE);
    add(RT, 1'b1, E_EXEC);     add(RT, 1'b1, E_RWB);
    // Unknown opcode
    add(BAD, 1'b1, E_FETCH_R); add(BAD, 1'b1, E_DECODE); add(BAD, 1'b1, E_ILL_OP);

    // Reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", E_IDLE);
    rst_n = 1'b1;

    foreach (tbl[i]) step($sformatf("row%0d", i), tbl[i].op, tbl[i].rdy, tbl[i].exp);

    // ILLEGAL is sticky regardless of inputs
    for (int k = 0; k < 20; k++)
      step($sformatf("ill_stuck%0d", k), 6'(k), k[0], E_ILL_OP);

    // Reset clears the sticky flag
    rst_n = 1'b0;
    #1;
    check("ill_reset", E_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    step("rel_idle", RT, 1'b0, E_IDLE);

    // Timeout: four waits in FETCH then ILLEGAL with mem_timeout only
    for (int k = 0; k < 4; k++)
      step($sformatf("to_wait%0d", k), RT, 1'b0, E_FETCH_W);
    step("to_fault", RT, 1'b0, E_ILL_TO);
    step("to_stuck", RT, 1'b1, E_ILL_TO);

    // Reset in the middle of a store wait drops mem_write at once
    rst_n = 1'b0;
    #1;
    check("to_reset", E_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    step("sw_idle", SW, 1'b0, E_IDLE);
    step("sw_fetch", SW, 1'b1, E_FETCH_R);
    step("sw_decode", SW, 1'b1, E_DECODE);
    step("sw_maddr", SW, 1'b1, E_MADDR);
    opcode = SW;
    mem_ready = 1'b0;
    #1;
    check("sw_wait", E_MWRITE);
    #2;
    rst_n = 1'b0;
    #1;
    check("sw_abort", E_IDLE);
    @(posedge clk);
    #1;
    check("sw_abort_hold", E_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM of the multicycle MIPS core. It drives the 3-bit alu_op consumed by the ALU control block, plus every datapath enable and mux select.
- The ALU control block maps alu_op together with the instruction function field to the ALU operation; this block decides, per cycle, which class of ALU operation is required.
- Sits between the instruction register (opcode) and the datapath. It performs a ready-based handshake with the memory for all memory states.

Parameters:
- OP_W, 6, opcode width.
- TIMEOUT, 16, maximum number of cycles in a memory state without mem_ready before faulting. 0 disables the timeout.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  OP_W  instr[31:26] from the IR; stable from DECODE until the next FETCH.
- mem_ready  input  1  memory completes the current read or write this cycle.
- alu_op  output  3  000=add, 001=subtract, 010=R-type (use func); 011..111 never driven.
- alu_src_a  output  1  0=PC, 1=register A.
- alu_src_b  output  2  00=register B, 01=constant 4, 10=sign-extended immediate, 11=immediate<<2.
- pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- pc_write, pc_write_cond  output  1 each  PC write enable; branch-conditional PC enable (the datapath ANDs it with zero).
- i_or_d  output  1  0=PC address, 1=ALUOut address.
- mem_read, mem_write  output  1 each  memory strobes.
- ir_write  output  1  instruction register load.
- reg_write, reg_dst, mem_to_reg  output  1 each  register-file write enable, rd/rt select, memory/ALU writeback select.
- illegal_op  output  1  sticky flag: unknown opcode.
- mem_timeout  output  1  sticky flag: memory wait exceeded TIMEOUT.
- state  output  4  current state, for debug.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, wait counter=0, every output 0. The first clock after rst_n deasserts moves IDLE to FETCH. Reset mid-instruction aborts immediately with no write enables asserted.
- Outputs are Moore functions of state. The only exceptions are the handshake-gated enables, which are also functions of mem_ready. Unlisted outputs are 0 in each state.
- State encodings are 0..13 in the order below. Unreachable codes 14 and 15 transition to IDLE.
  - IDLE: all outputs 0. Next state FETCH.
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00, ir_write=pc_write=mem_ready. Holds until mem_ready, then DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=000. Next state by opcode: 000000→EXECUTE, 100011 or 101011→MEM_ADDR, 000100→BRANCH, 000010→JUMP, 001000→ADDI_EXEC, anything else→ILLEGAL.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. lw→MEM_READ, sw→MEM_WRITE.
  - MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
  - MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready, then FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=010. Next state R_WB.
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01. Next state FETCH.
  - JUMP: pc_write=1, pc_source=10. Next state FETCH.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=000. Next state ADDI_WB.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
  - ILLEGAL: illegal_op=1, all enables 0. Stays until reset.
- Memory strobes stay high for the whole wait. The write enables gated by mem_ready fire exactly once, in the mem_ready cycle.
- Wait counter:
  - Clears on entry to FETCH, MEM_READ or MEM_WRITE, and increments each cycle mem_ready=0 in those states. It saturates and never wraps.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT with mem_ready still 0, the next state is ILLEGAL with mem_timeout=1 and illegal_op=0.
  - mem_ready=1 in the same cycle as the count reaching TIMEOUT completes normally; ready wins.
- Latency with zero wait states: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.

Test Plan:
- Reset: hold rst_n=0 3 cycles → all outputs 0, state=0. Release → IDLE, then FETCH one cycle later.
- R-type add: opcode=000000, mem_ready=1 → FETCH, DECODE, EXECUTE (alu_op=010), R_WB (reg_write=1, reg_dst=1), then FETCH.
- lw with 2 wait cycles in MEM_READ: opcode=100011 → MEM_READ held 3 cycles with mem_read=1, i_or_d=1. MEM_WB then has reg_write=1, mem_to_reg=1.
- beq: opcode=000100 → BRANCH with alu_op=001, pc_write_cond=1, pc_source=01. 3 cycles total.
- Illegal opcode: opcode=111111 → ILLEGAL, illegal_op=1, stays stuck across 20 cycles. Reset clears it.
- Timeout and mid-op reset:
  - TIMEOUT=4, mem_ready=0 in FETCH → ILLEGAL after 4 waits with mem_timeout=1.
  - Separately, asserting rst_n=0 during MEM_WRITE drops mem_write to 0 immediately.
